tx_gearbox_feed: RTL and testbench

//  Parametrised successor to the fixed 32-bit TX tail. Buffers 66b blocks ({head,data64}) from the encoder in a small FIFO.

---
 rtl/tx_gearbox_feed.sv | 150 +++++++++++++++
 tb/tb_tx_gearbox_feed.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_gearbox_feed.sv
// TX tail: 66b block FIFO, external-gearbox sequence counter with pause cycle, DATA_W serialiser, IDLE fill.
// Optional internal scrambler (1+x^39+x^58) enabled by defining TX_FEED_SCRAMBLE_EN.
module tx_gearbox_feed #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SEQ_MAX    = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [63:0]                   s_data_i,
  input  logic [1:0]                    s_head_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  output logic [DATA_W-1:0]             data_o,
  output logic [5:0]                    head_o,
  output logic [6:0]                    sequence_o,
  output logic                          underflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int unsigned WPB   = 64 / DATA_W;
  localparam int unsigned IDX_W = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [65:0] IDLE_BLK = {2'b10, 64'h0000_0000_0000_001E};

  logic [65:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              ready_q, ready_d;
  logic [6:0]        seq_q, seq_d, seqo_q, seqo_d;
  logic [IDX_W-1:0]  widx_q, widx_d;
  logic [63:0]       cur_data_q, cur_data_d;
  logic [1:0]        cur_head_q, cur_head_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [5:0]        head_q, head_d;
  logic              uf_q, uf_d;

  logic        push, pop, fifo_pop, empty;
  logic [65:0] raw_blk;
  logic [63:0] blk_data;

  // Pop decision and raw block selection (FIFO head or IDLE fill)
  always_comb begin
    empty    = (level_q == '0);
    push     = s_valid_i && ready_q;
    pop      = (seq_q != 7'(SEQ_MAX)) && (widx_q == '0);
    fifo_pop = pop && !empty;
    raw_blk  = empty ? IDLE_BLK : mem_q[rd_ptr_q];
  end

`ifdef TX_FEED_SCRAMBLE_EN
  logic [57:0] scr_q, scr_d, scr_st;
  logic        scr_bit;

  // Self-synchronous scrambler, bit 0 first; state holds the last 58 scrambled bits
  always_comb begin
    scr_st   = scr_q;
    scr_bit  = 1'b0;
    blk_data = '0;
    for (int i = 0; i < 64; i++) begin
      scr_bit     = raw_blk[i] ^ scr_st[38] ^ scr_st[57];
      blk_data[i] = scr_bit;
      scr_st      = {scr_st[56:0], scr_bit};
    end
    scr_d = pop ? scr_st : scr_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) scr_q <= '1;
    else       scr_q <= scr_d;
  end
`else
  always_comb blk_data = raw_blk[63:0];
`endif

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = fifo_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d    = level_q;
    if (push && !fifo_pop)      level_d = level_q + LVL_W'(1);
    else if (!push && fifo_pop) level_d = level_q - LVL_W'(1);
    ready_d    = (level_d < LVL_W'(FIFO_DEPTH));

    seq_d      = (seq_q == 7'(SEQ_MAX)) ? 7'd0 : seq_q + 7'd1;
    seqo_d     = seq_q;
    widx_d     = widx_q;
    cur_data_d = cur_data_q;
    cur_head_d = cur_head_q;
    data_d     = data_q;
    head_d     = head_q;
    uf_d       = pop && empty;

    // Pause cycle (seq==SEQ_MAX) leaves word index and outputs untouched
    if (seq_q != 7'(SEQ_MAX)) begin
      widx_d = (widx_q == IDX_W'(WPB - 1)) ? '0 : widx_q + IDX_W'(1);
      if (pop) begin
        cur_data_d = blk_data;
        cur_head_d = raw_blk[65:64];
        data_d     = blk_data[DATA_W-1:0];
        head_d     = {4'b0000, raw_blk[65:64]};
      end else begin
        data_d     = cur_data_q[DATA_W*int'(widx_q) +: DATA_W];
        head_d     = {4'b0000, cur_head_q};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {s_head_i, s_data_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ready_q    <= 1'b0;
      seq_q      <= '0;
      seqo_q     <= '0;
      widx_q     <= '0;
      cur_data_q <= '0;
      cur_head_q <= '0;
      data_q     <= '0;
      head_q     <= '0;
      uf_q       <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ready_q    <= ready_d;
      seq_q      <= seq_d;
      seqo_q     <= seqo_d;
      widx_q     <= widx_d;
      cur_data_q <= cur_data_d;
      cur_head_q <= cur_head_d;
      data_q     <= data_d;
      head_q     <= head_d;
      uf_q       <= uf_d;
    end
  end

  assign s_ready_o    = ready_q;
  assign data_o       = data_q;
  assign head_o       = head_q;
  assign sequence_o   = seqo_q;
  assign underflow_o  = uf_q;
  assign fifo_level_o = level_q;

endmodule

// File: tb/tb_tx_gearbox_feed.sv
// Bench for tx_gearbox_feed: randomized traffic against a block-queue reference model.
module tb_tx_gearbox_feed;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned SEQ_MAX    = 32;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned WPB        = 64 / DATA_W;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [63:0]       s_data_i;
  logic [1:0]        s_head_i;
  logic              s_valid_i;
  logic              s_ready_o;
  logic [DATA_W-1:0] data_o;
  logic [5:0]        head_o;
  logic [6:0]        sequence_o;
  logic              underflow_o;
  logic [2:0]        fifo_level_o;

  tx_gearbox_feed #(.DATA_W(DATA_W), .SEQ_MAX(SEQ_MAX), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .s_data_i(s_data_i), .s_head_i(s_head_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .data_o(data_o), .head_o(head_o),
    .sequence_o(sequence_o), .underflow_o(underflow_o), .fifo_level_o(fifo_level_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // Reference model: cycle count since reset, words consumed, queue of buffered blocks
  int          cyc, words;
  logic [65:0] mq[$];
  logic [63:0] cur_d;
  logic [1:0]  cur_h;
  logic [DATA_W-1:0] exp_data;
  logic [5:0]  exp_head;
  logic [6:0]  exp_seq;
  logic        exp_uf, exp_ready;
  logic [2:0]  exp_level;
  bit          hist[$];

  int          lvl_max;
  bit          ready_low_seen;
  bit          cap_en;
  logic [DATA_W-1:0] cap_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scrambled output bit y[n] = x[n] ^ y[n-39] ^ y[n-58], history seeded with ones
  function automatic logic [63:0] scramble(input logic [63:0] x);
`ifdef TX_FEED_SCRAMBLE_EN
    logic [63:0] y;
    bit b;
    for (int i = 0; i < 64; i++) begin
      b = x[i] ^ hist[hist.size() - 39] ^ hist[hist.size() - 58];
      y[i] = b;
      hist.push_back(b);
      void'(hist.pop_front());
    end
    return y;
`else
    return x;
`endif
  endfunction

  task automatic model_reset();
    cyc = 0; words = 0;
    mq.delete();
    cur_d = '0; cur_h = '0;
    exp_data = '0; exp_head = '0; exp_seq = '0; exp_uf = 1'b0;
    exp_ready = 1'b0; exp_level = '0;
    hist.delete();
    for (int i = 0; i < 58; i++) hist.push_back(1'b1);
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_data"},  64'(data_o),      64'(exp_data));
    check({pfx, "_head"},  64'(head_o),      64'(exp_head));
    check({pfx, "_seq"},   64'(sequence_o),  64'(exp_seq));
    check({pfx, "_uf"},    64'(underflow_o), 64'(exp_uf));
    check({pfx, "_ready"}, 64'(s_ready_o),   64'(exp_ready));
    check({pfx, "_level"}, 64'(fifo_level_o), 64'(exp_level));
  endtask

  // One clock: predict, advance, compare
  task automatic step(output logic accepted);
    logic [65:0] blk;
    int s, w;
    accepted = s_valid_i && exp_ready;
    s = cyc % (SEQ_MAX + 1);
    exp_uf = 1'b0;
    if (s != SEQ_MAX) begin
      w = words % WPB;
      if (w == 0) begin
        if (mq.size() > 0) blk = mq.pop_front();
        else begin
          blk = {2'b10, 64'h0000_0000_0000_001E};
          exp_uf = 1'b1;
        end
        cur_h = blk[65:64];
        cur_d = scramble(blk[63:0]);
      end
      exp_data = cur_d[DATA_W*w +: DATA_W];
      exp_head = {4'b0000, cur_h};
      words++;
    end
    exp_seq = 7'(s);
    if (accepted) mq.push_back({s_head_i, s_data_i});
    exp_level = 3'(mq.size());
    exp_ready = (mq.size() < FIFO_DEPTH);
    cyc++;
    @(posedge clk_i); #1;
    check_outputs("step");
    check("level_bound", 64'(fifo_level_o <= 3'(FIFO_DEPTH)), 64'd1);
    if (int'(fifo_level_o) > lvl_max) lvl_max = int'(fifo_level_o);
    if (!s_ready_o) ready_low_seen = 1'b1;
    if (cap_en && head_o == 6'h01 && sequence_o != 7'(SEQ_MAX)) cap_q.push_back(data_o);
  endtask

  task automatic run_traffic(input int n, input int pct);
    logic acc;
    acc = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (!s_valid_i || acc) begin
        s_valid_i = ($urandom_range(99) < pct);
        s_data_i  = {$urandom, $urandom};
        s_head_i  = ($urandom_range(1) == 1) ? 2'b01 : 2'b10;
      end
      step(acc);
    end
  endtask

  task automatic push_block(input logic [63:0] d, input logic [1:0] h, input string tag);
    logic acc;
    int n;
    acc = 1'b0; n = 0;
    s_valid_i = 1'b1; s_data_i = d; s_head_i = h;
    while (!acc && n < 20) begin
      step(acc);
      n++;
    end
    check(tag, 64'(acc), 64'd1);
    s_valid_i = 1'b0;
  endtask

  task automatic apply_reset(input string tag);
    rst_i = 1'b1;
    s_valid_i = 1'b0;
    #1;
    check({tag, "_data"},  64'(data_o),       64'd0);
    check({tag, "_head"},  64'(head_o),       64'd0);
    check({tag, "_seq"},   64'(sequence_o),   64'd0);
    check({tag, "_ready"}, 64'(s_ready_o),    64'd0);
    check({tag, "_uf"},    64'(underflow_o),  64'd0);
    check({tag, "_level"}, 64'(fifo_level_o), 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_reset();
  endtask

  initial begin
    int uf_cnt;
    logic acc;
    rst_i = 1'b1; s_valid_i = 1'b0; s_data_i = '0; s_head_i = 2'b01;
    lvl_max = 0; ready_low_seen = 1'b0; cap_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    apply_reset("rst_init");

    // Idle only: IDLE fill with one underflow pulse per block
    for (int i = 0; i < 40; i++) step(acc);
    uf_cnt = 0;
    for (int i = 0; i < 33; i++) begin
      step(acc);
      if (underflow_o) uf_cnt++;
    end
    check("uf_per_33", 64'(uf_cnt), 64'd16);

    // Two directed data blocks
    cap_en = 1'b1;
    push_block(64'hA5A5_0000_1111_2222, 2'b01, "push_a");
    push_block(64'h0123_4567_89AB_CDEF, 2'b01, "push_b");
    for (int i = 0; i < 40; i++) step(acc);
    cap_en = 1'b0;
`ifndef TX_FEED_SCRAMBLE_EN
    check("cap_count", 64'(cap_q.size()), 64'd4);
    if (cap_q.size() == 4) begin
      check("cap_w0", 64'(cap_q[0]), 64'h1111_2222);
      check("cap_w1", 64'(cap_q[1]), 64'hA5A5_0000);
      check("cap_w2", 64'(cap_q[2]), 64'h89AB_CDEF);
      check("cap_w3", 64'(cap_q[3]), 64'h0123_4567);
    end
`endif

    // Random stream crossing several pause cycles
    run_traffic(200, 60);

    // Source always valid: FIFO fills, ready drops, level capped
    lvl_max = 0; ready_low_seen = 1'b0;
    run_traffic(80, 100);
    check("lvl_max", 64'(lvl_max), 64'(FIFO_DEPTH));
    check("ready_low_seen", 64'(ready_low_seen), 64'd1);

    // Reset mid-block while traffic is flowing
    run_traffic(7, 100);
    apply_reset("rst_mid");
    run_traffic(150, 50);
    run_traffic(40, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
